// File: rtl/spw_slot_ctrl_if.sv
// Handshake and buffer-port bundle between the slot controller and its neighbours.
// master drives upstream/downstream requests; slave is the controller itself.
interface spw_slot_ctrl_if #(
   parameter int PTR_WIDTH  = 3,
   parameter int DATA_WIDTH = 128
);
   logic                   flush_i;
   logic                   in_valid_i;
   logic                   in_ready_o;
   logic [DATA_WIDTH-1:0]  in_data_i;
   logic                   out_valid_o;
   logic                   out_ready_i;
   logic [PTR_WIDTH-1:0]   out_ptr_o;
   logic                   wr_en_o;
   logic [PTR_WIDTH-1:0]   write_ptr_o;
   logic [DATA_WIDTH-1:0]  write_data_o;
   logic                   rd_en_o;
   logic [PTR_WIDTH-1:0]   read_ptr_o;
   logic [PTR_WIDTH:0]     count_o;

   modport master (
      output flush_i, in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_ptr_o, wr_en_o, write_ptr_o,
             write_data_o, rd_en_o, read_ptr_o, count_o
   );

   modport slave (
      input  flush_i, in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_ptr_o, wr_en_o, write_ptr_o,
             write_data_o, rd_en_o, read_ptr_o, count_o
   );
endinterface

// File: rtl/spw_slot_ctrl.sv
// Slot allocator and arrival-order tracker sitting in front of spw_buffer.
// Hands out the lowest free slot on write and releases slots in FIFO order on read.
module spw_slot_ctrl #(
   parameter int PTR_WIDTH  = 3,
   parameter int DATA_WIDTH = 128
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   spw_slot_ctrl_if.slave  bus
);
   localparam int DEPTH = 1 << PTR_WIDTH;
   localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

   typedef logic [PTR_WIDTH-1:0] ptr_t;

   logic [DEPTH-1:0]   free_q, free_d;
   ptr_t               head_q, head_d;
   ptr_t               tail_q, tail_d;
   logic [PTR_WIDTH:0] count_q, count_d;
   ptr_t               queue_q [DEPTH];
   ptr_t               queue_d [DEPTH];

   ptr_t alloc_ptr;
   ptr_t head_ptr;
   logic in_ready;
   logic out_valid;
   logic wr_en;
   logic rd_en;

   always_comb begin
      alloc_ptr = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (free_q[i]) alloc_ptr = ptr_t'(i);
      end
   end

   // Ready/valid come from registered count only, so no input-to-output comb path.
   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign head_ptr  = queue_q[head_q];
   assign wr_en     = bus.in_valid_i & in_ready;
   assign rd_en     = out_valid & bus.out_ready_i;

   assign bus.in_ready_o   = in_ready;
   assign bus.out_valid_o  = out_valid;
   assign bus.out_ptr_o    = head_ptr;
   assign bus.read_ptr_o   = head_ptr;
   assign bus.wr_en_o      = wr_en;
   assign bus.rd_en_o      = rd_en;
   assign bus.write_ptr_o  = alloc_ptr;
   assign bus.write_data_o = bus.in_data_i;
   assign bus.count_o      = count_q;

   always_comb begin
      free_d  = free_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      queue_d = queue_q;
      if (rd_en) begin
         free_d[head_ptr] = 1'b1;
         head_d           = head_q + ptr_t'(1);
      end
      // A slot released this cycle was allocated, so it can never collide with alloc_ptr.
      if (wr_en) begin
         free_d[alloc_ptr] = 1'b0;
         tail_d            = tail_q + ptr_t'(1);
         if (!bus.flush_i && rst_ni) queue_d[tail_q] = alloc_ptr;
      end
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase
      if (bus.flush_i) begin
         free_d  = '1;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         free_q  <= '1;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         free_q  <= free_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Order storage carries data only; it is never cleared.
   always_ff @(posedge clk_i) begin
      queue_q <= queue_d;
   end
endmodule
